// File: rtl/rst_seq_ctrl.sv
// Staged reset release across NUM_CH domains, run-cycle counter and soft re-sequence.
// Heartbeat watchdog is compiled in only when RST_SEQ_WDT_EN is defined.
module rst_seq_ctrl #(
  parameter int NUM_CH       = 4,
  parameter int HOLD_CYCLES  = 2,
  parameter int STAGE_CYCLES = 4,
  parameter int CNT_W        = 32,
  parameter int WDT_CYCLES   = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              soft_rst_req_i,
  input  logic              heartbeat_i,
  output logic [NUM_CH-1:0] rst_out_o,
  output logic              all_released_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              wdt_fired_o,
  output logic              busy_o
);
  localparam int TMAX = (HOLD_CYCLES > STAGE_CYCLES) ? HOLD_CYCLES : STAGE_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int CW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [TW-1:0] HOLD_LAST  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] STAGE_LAST = TW'(STAGE_CYCLES - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_HOLD, S_STAGE, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0] rst_out_q, rst_out_d;
  logic              rel_q, rel_d;
  logic              busy_q, busy_d;
  logic              fired_q, fired_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wdt_to;

`ifdef RST_SEQ_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_CYCLES - 1);
  logic [WW-1:0] wdt_q, wdt_d;

  // A heartbeat on the would-be timeout edge suppresses the timeout.
  assign wdt_to = (state_q == S_RUN) && !heartbeat_i && (wdt_q == WDT_LAST);

  always_comb begin
    wdt_d = '0;
    if (state_q == S_RUN && !soft_rst_req_i && !heartbeat_i && !wdt_to)
      wdt_d = wdt_q + 1'b1;
  end
`else
  logic unused_wdt;
  assign unused_wdt = heartbeat_i ^ (WDT_CYCLES < 1);
  assign wdt_to     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    ch_d      = ch_q;
    rst_out_d = rst_out_q;
    rel_d     = rel_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    fired_d   = fired_q | wdt_to;
    if (soft_rst_req_i || wdt_to) begin
      state_d   = S_HOLD;
      timer_d   = '0;
      ch_d      = '0;
      rst_out_d = '1;
      rel_d     = 1'b0;
      busy_d    = 1'b1;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (timer_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            timer_d      = '0;
            if (NUM_CH == 1) begin
              state_d = S_RUN;
              rel_d   = 1'b1;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              state_d = S_STAGE;
              ch_d    = CW'(1);
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_STAGE: begin
          if (timer_q == STAGE_LAST) begin
            rst_out_d = rst_out_q & ~(NUM_CH'(1) << ch_q);
            timer_d   = '0;
            if (ch_q == CH_LAST) begin
              state_d = S_RUN;
              rel_d   = 1'b1;
              busy_d  = 1'b0;
              cnt_d   = '0;
            end else begin
              ch_d = ch_q + 1'b1;
            end
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
        S_RUN: begin
          // Saturate rather than wrap so long runs stay distinguishable.
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_HOLD;
      timer_q   <= '0;
      ch_q      <= '0;
      rst_out_q <= '1;
      rel_q     <= 1'b0;
      busy_q    <= 1'b1;
      cnt_q     <= '0;
      fired_q   <= 1'b0;
`ifdef RST_SEQ_WDT_EN
      wdt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      ch_q      <= ch_d;
      rst_out_q <= rst_out_d;
      rel_q     <= rel_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      fired_q   <= fired_d;
`ifdef RST_SEQ_WDT_EN
      wdt_q     <= wdt_d;
`endif
    end
  end

  assign rst_out_o      = rst_out_q;
  assign all_released_o = rel_q;
  assign cycle_cnt_o    = cnt_q;
  assign wdt_fired_o    = fired_q;
  assign busy_o         = busy_q;
endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Scoreboard bench: expected outputs derived from edge counts since the last start.
module tb_rst_seq_ctrl;
  localparam int HOLD  = 2;
  localparam int STAGE = 4;
  localparam int NCH   = 4;
  localparam int REL0  = HOLD + (NCH - 1) * STAGE;
  localparam int WDT   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1, soft_req = 1'b0, hb = 1'b0;
  logic [3:0] ro0;
  logic       ar0, wf0, bz0;
  logic [31:0] cc0;
  logic [0:0] ro1;
  logic       ar1, wf1, bz1;
  logic [3:0] cc1;

  always #5 clk = ~clk;

  rst_seq_ctrl #(.NUM_CH(NCH), .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE),
                 .CNT_W(32), .WDT_CYCLES(WDT)) dut (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(soft_req), .heartbeat_i(hb),
    .rst_out_o(ro0), .all_released_o(ar0), .cycle_cnt_o(cc0),
    .wdt_fired_o(wf0), .busy_o(bz0));

  rst_seq_ctrl #(.NUM_CH(1), .HOLD_CYCLES(HOLD), .STAGE_CYCLES(STAGE),
                 .CNT_W(4), .WDT_CYCLES(1024)) dut1 (
    .clk_i(clk), .rst_i(rst), .soft_rst_req_i(soft_req), .heartbeat_i(hb),
    .rst_out_o(ro1), .all_released_o(ar1), .cycle_cnt_o(cc1),
    .wdt_fired_o(wf1), .busy_o(bz1));

  typedef struct {
    logic [3:0]  ro0;
    logic        ar0;
    logic [31:0] cc0;
    logic        bz0;
    logic        wf0;
    logic        ro1;
    logic        ar1;
    logic [3:0]  cc1;
  } exp_t;

  exp_t sb[$];
  int ncmp = 0, nerr = 0;
  int e0 = 0, e1 = 0, miss = 0;
  bit fired = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ro_exp(input int e);
    logic [3:0] r;
    for (int i = 0; i < NCH; i++) r[i] = (e < HOLD + i * STAGE);
    return r;
  endfunction

  // One clock edge: advance the model, queue its prediction, then compare.
  task automatic tick(input bit r, input bit s, input bit h);
    exp_t x, y;
    rst = r; soft_req = s; hb = h;
    if (r) begin
      e0 = 0; miss = 0; fired = 1'b0;
    end else if (s) begin
      e0 = 0; miss = 0;
    end else begin
`ifdef RST_SEQ_WDT_EN
      if (e0 >= REL0) miss = h ? 0 : miss + 1;
      else miss = 0;
      if (miss == WDT) begin
        e0 = 0; miss = 0; fired = 1'b1;
      end else e0++;
`else
      e0++;
`endif
    end
    e1 = (r || s) ? 0 : e1 + 1;
    x.ro0 = ro_exp(e0);
    x.ar0 = (e0 >= REL0);
    x.cc0 = (e0 >= REL0) ? 32'(e0 - REL0) : 32'd0;
    x.bz0 = (e0 < REL0);
    x.wf0 = fired;
    x.ro1 = (e1 < HOLD);
    x.ar1 = (e1 >= HOLD);
    x.cc1 = (e1 < HOLD) ? 4'd0 : ((e1 - HOLD > 15) ? 4'd15 : 4'(e1 - HOLD));
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    chk("rst_out",       64'(ro0), 64'(y.ro0));
    chk("all_released",  64'(ar0), 64'(y.ar0));
    chk("cycle_cnt",     64'(cc0), 64'(y.cc0));
    chk("busy",          64'(bz0), 64'(y.bz0));
    chk("wdt_fired",     64'(wf0), 64'(y.wf0));
    chk("ch1_rst_out",   64'(ro1), 64'(y.ro1));
    chk("ch1_released",  64'(ar1), 64'(y.ar1));
    chk("ch1_busy",      64'(bz1), 64'(!y.ar1));
    chk("ch1_cycle_cnt", 64'(cc1), 64'(y.cc1));
    chk("ch1_wdt_fired", 64'(wf1), 64'd0);
  endtask

  initial begin
    // Reset held for three edges.
    for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 1'b1);
    // Full release, counting in RUN, 4-bit counter saturation.
    for (int k = 0; k < 30; k++) tick(1'b0, 1'b0, 1'b1);
    // Single-edge soft restart from RUN.
    tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b0, 1'b1);
    // Soft request held high pins the block in HOLD.
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 18; k++) tick(1'b0, 1'b0, 1'b1);
    // Hard reset mid-STAGE, then full re-sequence.
    tick(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) tick(1'b0, 1'b0, 1'b1);
    // Heartbeat silent in RUN: timeout only with the watchdog built in.
    for (int k = 0; k < 24; k++) tick(1'b0, 1'b0, 1'b0);
    // Heartbeat on exactly every 8th edge lands on the would-be timeout edge.
    tick(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) tick(1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 24; k++) tick(1'b0, 1'b0, (k % 8) == 7);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
